req_pending_ctrl: RTL and testbench

- Upstream stage of the 4-to-2 priority encoder path.
- Detects rising edges on raw request lines and latches them as sticky pending bits.
- Presents the highest-priority pending request as a registered index with a valid/ready handshake.
- Clears the served bit on acceptance.
- Bit 3 has the highest priority, bit 0 the lowest; this matches the downstream encoder ordering.

---
 rtl/req_pkg.sv | 25 ++
 rtl/req_edge_latch.sv | 65 ++++++
 rtl/req_pending_ctrl.sv | 105 ++++++++++
 tb/tb_req_pending_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/req_pkg.sv
// req_pkg
//   Shared definitions for the request-pending controller: default sizing,
//   FSM state encoding and the priority selection helper.
//   Optional feature macro used by the controller: REQ_MASK_EN.
package req_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int IDX_W_DEF   = 2;
  localparam int MAX_REQ     = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Index of the highest set bit (bit MAX_REQ-1 wins). A zero vector yields 0,
  // so callers must qualify the result with |vec.
  function automatic int highest_set(input logic [MAX_REQ-1:0] vec);
    highest_set = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) highest_set = i;
    end
  endfunction

endpackage

// File: rtl/req_edge_latch.sv
// req_edge_latch
//   Rising-edge detector and sticky pending register for the request lines.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous active-high reset
//     req      in   raw request levels [NUM_REQ-1:0]
//     clr_en   in   the presented request is accepted this cycle
//     clr_idx  in   index of the accepted request [IDX_W-1:0]
//     pend     out  pending register [NUM_REQ-1:0]
//     lost     out  registered pulse: an edge hit an already pending bit
module req_edge_latch
  import req_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               clr_en,
  input  logic [IDX_W-1:0]   clr_idx,
  output logic [NUM_REQ-1:0] pend,
  output logic               lost
);

  logic [NUM_REQ-1:0] r_req_d;
  logic [NUM_REQ-1:0] r_pend;
  logic               r_lost;
  logic [NUM_REQ-1:0] w_rise;
  logic [NUM_REQ-1:0] w_clr;
  logic [NUM_REQ-1:0] w_pend_prev;

  always_comb begin
    w_rise = req & ~r_req_d;
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_clr[i] = clr_en && (clr_idx == IDX_W'(i));
    end
  end

  // A bit being served this cycle is no longer "already pending", so a fresh
  // edge on it is a new event rather than a lost one; set wins over clear.
  always_comb begin
    w_pend_prev = r_pend & ~w_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_d <= '0;
      r_pend  <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_req_d <= req;
      r_pend  <= w_pend_prev | w_rise;
      r_lost  <= |(w_rise & w_pend_prev);
    end
  end

  assign pend = r_pend;
  assign lost = r_lost;

endmodule

// File: rtl/req_pending_ctrl.sv
// req_pending_ctrl
//   Latches rising edges on request lines as pending bits and presents the
//   highest-priority pending request (highest index wins) over a valid/ready
//   handshake. One bubble cycle separates consecutive grants.
//   Ports:
//     clk        in   system clock
//     rst        in   asynchronous active-high reset
//     req        in   raw request levels [NUM_REQ-1:0]
//     req_mask   in   per-bit selection mask, 1 = masked (only with REQ_MASK_EN)
//     out_valid  out  a request index is being presented
//     out_ready  in   consumer accepts the presented index
//     out_idx    out  presented index [IDX_W-1:0]
//     pend       out  pending register readback [NUM_REQ-1:0]
//     lost       out  one-cycle pulse on an edge hitting an already pending bit
//   Optional macro: REQ_MASK_EN adds req_mask.
module req_pending_ctrl
  import req_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = IDX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
`ifdef REQ_MASK_EN
  input  logic [NUM_REQ-1:0] req_mask,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_idx,
  output logic [NUM_REQ-1:0] pend,
  output logic               lost
);

  state_t             r_state;
  logic               r_valid;
  logic [IDX_W-1:0]   r_idx;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_pend;
  logic [NUM_REQ-1:0] w_elig;
  logic [MAX_REQ-1:0] w_elig_wide;

  assign w_accept = r_valid & out_ready;

  req_edge_latch #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_edge_latch (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .clr_en  (w_accept),
    .clr_idx (r_idx),
    .pend    (w_pend),
    .lost    (lost)
  );

  // Masking only affects selection; masked bits keep latching and stay
  // visible on pend.
`ifdef REQ_MASK_EN
  assign w_elig = w_pend & ~req_mask;
`else
  assign w_elig = w_pend;
`endif

  always_comb begin
    w_elig_wide = '0;
    w_elig_wide[NUM_REQ-1:0] = w_elig;
  end

  // The index is captured once on entry to PRESENT and held until acceptance,
  // so a later higher-priority arrival never changes an in-flight grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_elig) begin
            r_idx   <= IDX_W'(highest_set(w_elig_wide));
            r_valid <= 1'b1;
            r_state <= PRESENT;
          end
        end
        PRESENT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_idx   = r_idx;
  assign pend      = w_pend;

endmodule

// File: tb/tb_req_pending_ctrl.sv
module tb_req_pending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_idx;
  logic [3:0] pend;
  logic       lost;
`ifdef REQ_MASK_EN
  logic [3:0] req_mask = 4'b0000;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  req_pending_ctrl #(.NUM_REQ(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
`ifdef REQ_MASK_EN
    .req_mask  (req_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pend      (pend),
    .lost      (lost)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted grant must match the next expected index.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("grant_unexpected", 16'(out_idx), 16'hffff);
      else chk("grant_idx", 16'(out_idx), 16'(exp_q.pop_front()));
    end
  end

  initial begin
    // Reset state, observed with no clock edge yet.
    #2;
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_idx",   16'(out_idx),   16'h0);
    chk("rst_pend",  16'(pend),      16'h0);
    chk("rst_lost",  16'(lost),      16'h0);
    tick();
    tick();
    rst = 1'b0;

    // Single request on bit 2.
    req = 4'b0100; out_ready = 1'b1; exp_q.push_back(2'd2);
    tick();
    chk("t1_pend_set", 16'(pend), 16'h4);
    chk("t1_valid_lo", 16'(out_valid), 16'h0);
    req = 4'b0000;
    tick();
    chk("t1_valid", 16'(out_valid), 16'h1);
    chk("t1_idx",   16'(out_idx),   16'h2);
    chk("t1_lost",  16'(lost),      16'h0);
    tick();
    chk("t1_valid_done", 16'(out_valid), 16'h0);
    chk("t1_pend_clr",   16'(pend),      16'h0);

    // Two simultaneous requests: bit 1 before bit 0 with a bubble between.
    req = 4'b0011; exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    tick();
    chk("t2_pend", 16'(pend), 16'h3);
    req = 4'b0000;
    tick();
    chk("t2_idx1", 16'(out_idx), 16'h1);
    chk("t2_v1",   16'(out_valid), 16'h1);
    tick();
    chk("t2_bubble", 16'(out_valid), 16'h0);
    chk("t2_pend1",  16'(pend), 16'h1);
    tick();
    chk("t2_idx0", 16'(out_idx), 16'h0);
    chk("t2_v0",   16'(out_valid), 16'h1);
    tick();
    chk("t2_pend0", 16'(pend), 16'h0);
    chk("t2_vdone", 16'(out_valid), 16'h0);

    // Grant held stable while a higher-priority request arrives.
    out_ready = 1'b0;
    req = 4'b0001; exp_q.push_back(2'd0); exp_q.push_back(2'd3);
    tick();
    req = 4'b0000;
    tick();
    chk("t3_idx0", 16'(out_idx), 16'h0);
    req = 4'b1000;
    tick();
    chk("t3_pend", 16'(pend), 16'h9);
    chk("t3_hold", 16'(out_idx), 16'h0);
    chk("t3_vhold", 16'(out_valid), 16'h1);
    req = 4'b0000;
    tick();
    out_ready = 1'b1;
    tick();
    chk("t3_pend8", 16'(pend), 16'h8);
    tick();
    chk("t3_idx3", 16'(out_idx), 16'h3);
    tick();
    chk("t3_pend0", 16'(pend), 16'h0);

    // Double pulse before service: one lost pulse, one grant.
    out_ready = 1'b0;
    req = 4'b0010; exp_q.push_back(2'd1);
    tick();
    chk("t4_lost0", 16'(lost), 16'h0);
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick();
    chk("t4_lost1", 16'(lost), 16'h1);
    req = 4'b0000;
    tick();
    chk("t4_lost_end", 16'(lost), 16'h0);
    out_ready = 1'b1;
    tick();
    chk("t4_pend0", 16'(pend), 16'h0);
    tick();
    chk("t4_no_regrant", 16'(out_valid), 16'h0);
    out_ready = 1'b0;

    // Acceptance coinciding with a new edge on the same bit.
    req = 4'b0100; exp_q.push_back(2'd2); exp_q.push_back(2'd2);
    tick();
    req = 4'b0000;
    tick();
    chk("t5_idx", 16'(out_idx), 16'h2);
    req = 4'b0100; out_ready = 1'b1;
    tick();
    chk("t5_pend_kept", 16'(pend), 16'h4);
    chk("t5_lost", 16'(lost), 16'h0);
    chk("t5_bubble", 16'(out_valid), 16'h0);
    req = 4'b0000;
    tick();
    chk("t5_regrant", 16'(out_valid), 16'h1);
    chk("t5_idx2", 16'(out_idx), 16'h2);
    tick();
    chk("t5_pend0", 16'(pend), 16'h0);
    out_ready = 1'b0;

    // Asynchronous reset while presenting.
    req = 4'b1010;
    tick();
    req = 4'b0000;
    tick();
    chk("t6_pre_valid", 16'(out_valid), 16'h1);
    chk("t6_pre_pend", 16'(pend), 16'ha);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", 16'(out_valid), 16'h0);
    chk("t6_async_pend",  16'(pend),      16'h0);
    chk("t6_async_idx",   16'(out_idx),   16'h0);
    req = 4'b0001;
    tick();
    chk("t6_held_pend", 16'(pend), 16'h0);
    rst = 1'b0;
    // Request already high at release counts as one edge, never more.
    tick();
    chk("t7_pend", 16'(pend), 16'h1);
    out_ready = 1'b1; exp_q.push_back(2'd0);
    tick();
    chk("t7_idx", 16'(out_idx), 16'h0);
    tick();
    chk("t7_pend0", 16'(pend), 16'h0);
    tick();
    chk("t7_no_retrig", 16'(out_valid), 16'h0);
    chk("t7_pend_still0", 16'(pend), 16'h0);
    req = 4'b0000;
    out_ready = 1'b0;

`ifdef REQ_MASK_EN
    // Masked pending bit waits until the mask is lifted.
    req_mask = 4'b1000; req = 4'b1000;
    tick();
    chk("m_pend", 16'(pend), 16'h8);
    req = 4'b0000;
    tick();
    chk("m_blocked0", 16'(out_valid), 16'h0);
    tick();
    chk("m_blocked1", 16'(out_valid), 16'h0);
    req_mask = 4'b0000; out_ready = 1'b1; exp_q.push_back(2'd3);
    tick();
    chk("m_idx3", 16'(out_idx), 16'h3);
    chk("m_valid", 16'(out_valid), 16'h1);
    tick();
    chk("m_pend0", 16'(pend), 16'h0);
    out_ready = 1'b0;
`endif

    tick();
    chk("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
